// File: rtl/heartbeat_pkg.sv
// Shared state encoding for the heartbeat burst controller.
// Latency: n/a (types only).
// Backpressure: n/a.
package heartbeat_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } hb_state_e;

endpackage

// File: rtl/heartbeat_cnt.sv
// N-bit clear/increment counter with a terminal-compare flag, shared by the RUN and GAP phases.
// Latency: count updates one edge after clr_i/inc_i; hit_o is combinational on the current count.
// Backpressure: none; the caller decides when to clear or advance.
module heartbeat_cnt #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic [N-1:0] term_i,
    output logic         hit_o
);

    logic [N-1:0] cnt_q;
    logic [N-1:0] cnt_d;

    // Clear wins over increment; arithmetic wraps naturally modulo 2^N.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + {{(N-1){1'b0}}, 1'b1};
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = (cnt_q == term_i);

endmodule

// File: rtl/heartbeat_ctrl.sv
// Burst heartbeat generator: emits cfg_count single-cycle pulses spaced cfg_period+1 apart, then cfg_gap quiet cycles.
// Latency: first pulse period+1 cycles after acceptance; out/done registered.
// Backpressure: cfg_ready only in IDLE; optional sticky irq enabled by defining HEARTBEAT_IRQ_EN.
module heartbeat_ctrl
    import heartbeat_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          nreset,
    inout  wire           vccd1,
    inout  wire           vssd1,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [N-1:0]  cfg_period,
    input  logic [CW-1:0] cfg_count,
    input  logic [N-1:0]  cfg_gap,
    input  logic          abort,
    output logic          out,
    output logic          busy,
    output logic          done
`ifdef HEARTBEAT_IRQ_EN
    ,
    output logic          irq,
    input  logic          irq_clr
`endif
);

    localparam logic [N-1:0]  ONE_N  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] ONE_CW = {{(CW-1){1'b0}}, 1'b1};

    // Supply pins carry no logic; fold them into a sink so they are visibly consumed.
    wire unused_pwr = &{1'b0, vccd1, vssd1};

    hb_state_e     state_q;
    logic [N-1:0]  period_q;
    logic [N-1:0]  gap_q;
    logic [CW-1:0] remaining_q;
    logic          out_q;
    logic          done_q;

    logic          accept;
    logic          pulse;
    logic          last_pulse;
    logic          done_d;
    logic          cnt_clr;
    logic          cnt_hit;
    logic [N-1:0]  cnt_term;

    assign cfg_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out       = out_q;
    assign done      = done_q;

    // In GAP the last quiet cycle is when the count reaches gap-1, so GAP lasts exactly gap cycles.
    assign cnt_term = (state_q == GAP) ? (gap_q - ONE_N) : period_q;

    // Counter sits at zero while idle, restarts on every pulse (also entering GAP) and on abort.
    assign cnt_clr = !busy || abort || cnt_hit;

    heartbeat_cnt #(.N(N)) u_cnt (
        .clk    (clk),
        .nreset (nreset),
        .clr_i  (cnt_clr),
        .inc_i  (busy),
        .term_i (cnt_term),
        .hit_o  (cnt_hit)
    );

    // Decode the events of this edge; abort suppresses any pulse or completion in flight.
    always_comb begin
        accept     = cfg_valid && (state_q == IDLE);
        pulse      = (state_q == RUN) && !abort && cnt_hit;
        last_pulse = pulse && (remaining_q == ONE_CW);
        done_d     = (accept && (cfg_count == '0))
                   || (last_pulse && (gap_q == '0))
                   || ((state_q == GAP) && !abort && cnt_hit);
    end

    // Burst FSM with registered out/done strobes; config is captured only at acceptance.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= IDLE;
            period_q    <= '0;
            gap_q       <= '0;
            remaining_q <= '0;
            out_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            out_q  <= pulse;
            done_q <= done_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        period_q    <= cfg_period;
                        gap_q       <= cfg_gap;
                        remaining_q <= cfg_count;
                        if (cfg_count != '0) begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_q <= IDLE;
                    end else if (pulse) begin
                        remaining_q <= remaining_q - ONE_CW;
                        if (last_pulse) begin
                            state_q <= (gap_q == '0) ? IDLE : GAP;
                        end
                    end
                end
                GAP: begin
                    if (abort || cnt_hit) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef HEARTBEAT_IRQ_EN
    logic irq_q;
    logic irq_d;

    // Sticky completion flag; a new completion beats a clear on the same edge.
    always_comb begin
        irq_d = irq_q;
        if (done_d) begin
            irq_d = 1'b1;
        end else if (irq_clr) begin
            irq_d = 1'b0;
        end
    end

    // Interrupt register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_heartbeat_ctrl.sv
// Scoreboard bench for heartbeat_ctrl: stimulus pushes expected out/done events, a negedge monitor pops them.
// Cycle numbering: after posedge k the counter cyc reads k; bursts accepted at edge A expect pulses at A+i*(period+1).
// Define HEARTBEAT_IRQ_EN to also exercise the sticky interrupt.
module tb_heartbeat_ctrl;

    localparam int N  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    wire           vccd1 = 1'b1;
    wire           vssd1 = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [N-1:0]  cfg_period = '0;
    logic [CW-1:0] cfg_count = '0;
    logic [N-1:0]  cfg_gap = '0;
    logic          abort = 1'b0;
    logic          out;
    logic          busy;
    logic          done;
`ifdef HEARTBEAT_IRQ_EN
    logic          irq;
    logic          irq_clr = 1'b0;
`endif

    typedef struct {
        int   cyc;
        logic out;
        logic done;
    } ev_t;

    ev_t exp_q[$];
    ev_t ev;
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;

    heartbeat_ctrl #(.N(N), .CW(CW)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .vccd1      (vccd1),
        .vssd1      (vssd1),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_count  (cfg_count),
        .cfg_gap    (cfg_gap),
        .abort      (abort),
        .out        (out),
        .busy       (busy),
        .done       (done)
`ifdef HEARTBEAT_IRQ_EN
        ,
        .irq        (irq),
        .irq_clr    (irq_clr)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every out/done assertion must match the head of the expected queue.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_event: expected out=%0b done=%0b at cycle %0d, still outstanding at cycle %0d",
                     exp_q[0].out, exp_q[0].done, exp_q[0].cyc, cyc);
            void'(exp_q.pop_front());
        end
        if (out === 1'b1 || done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                errors++;
                $display("FAIL unexpected_output: cycle %0d got out=%0b done=%0b, required no event", cyc, out, done);
            end else begin
                ev = exp_q.pop_front();
                if (out !== ev.out || done !== ev.done) begin
                    errors++;
                    $display("FAIL event_value: cycle %0d got out=%0b done=%0b, required out=%0b done=%0b",
                             cyc, out, done, ev.out, ev.done);
                end
            end
        end
    end

    task automatic chk(input string name, input logic act, input logic expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: cycle %0d got %0b required %0b", name, cyc, act, expv);
        end
    endtask

    task automatic wait_cyc(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    // Issue one request at a negedge; keep limits how many pulses are expected (negative = whole burst).
    task automatic issue(input logic [N-1:0] p, input logic [CW-1:0] n, input logic [N-1:0] g,
                         input int keep, output int acc);
        int t;
        chk("ready_before_issue", cfg_ready, 1'b1);
        cfg_valid  = 1'b1;
        cfg_period = p;
        cfg_count  = n;
        cfg_gap    = g;
        acc = cyc + 1;
        if (n == 0) begin
            exp_q.push_back('{acc, 1'b0, 1'b1});
        end else begin
            for (int i = 1; i <= int'(n); i++) begin
                if (keep < 0 || i <= keep) begin
                    t = acc + i * (int'(p) + 1);
                    exp_q.push_back('{t, 1'b1, (i == int'(n)) && (g == 0)});
                end
            end
            if (keep < 0 && g != 0) begin
                t = acc + int'(n) * (int'(p) + 1) + int'(g);
                exp_q.push_back('{t, 1'b0, 1'b1});
            end
        end
        @(posedge clk);
        #1;
        cfg_valid  = 1'b0;
        cfg_period = N'($urandom);
        cfg_count  = CW'($urandom);
        cfg_gap    = N'($urandom);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;

        // Reset state
        #12;
        chk("rst_out", out, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", cfg_ready, 1'b1);
`ifdef HEARTBEAT_IRQ_EN
        chk("rst_irq", irq, 1'b0);
`endif
        @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);

        // period=3 count=4 gap=0: pulses A+4,8,12,16, done with the last pulse
        issue(8'd3, 4'd4, 8'd0, -1, a);
        for (int k = 1; k <= 15; k++) begin
            wait_cyc(a + k);
            chk("busy_run", busy, 1'b1);
        end
        wait_cyc(a + 16);
        chk("busy_after_last", busy, 1'b0);

        // Back-to-back: period=0 count=3 gap=5: pulses A+1..3, done A+8
        issue(8'd0, 4'd3, 8'd5, -1, a);
        wait_cyc(a + 7);
        chk("ready_in_gap", cfg_ready, 1'b0);
        chk("busy_in_gap", busy, 1'b1);
        wait_cyc(a + 8);
        chk("ready_after_gap", cfg_ready, 1'b1);

        // count=0: done at A, never busy
        issue(8'd5, 4'd0, 8'd9, -1, a);
        wait_cyc(a);
        chk("busy_count0", busy, 1'b0);
        wait_cyc(a + 1);
        chk("busy_count0_next", busy, 1'b0);
        chk("ready_count0", cfg_ready, 1'b1);

        // period=7 count=5, abort in cycle A+10: single pulse at A+8, no done
        issue(8'd7, 4'd5, 8'd2, 1, a);
        wait_cyc(a + 10);
        chk("busy_before_abort", busy, 1'b1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        wait_cyc(a + 11);
        chk("busy_after_abort", busy, 1'b0);
        chk("ready_after_abort", cfg_ready, 1'b1);
        wait_cyc(a + 20);
        chk("idle_stays_after_abort", busy, 1'b0);

        // abort while idle does not block a simultaneous request
        abort = 1'b1;
        issue(8'd1, 4'd2, 8'd0, -1, a);
        abort = 1'b0;
        wait_cyc(a + 1);
        chk("busy_idle_abort_accept", busy, 1'b1);
        wait_cyc(a + 5);
        chk("busy_idle_abort_end", busy, 1'b0);

        // Reset during the second pulse interval abandons the burst
        issue(8'd3, 4'd4, 8'd0, 1, a);
        wait_cyc(a + 6);
        #2;
        nreset = 1'b0;
        #1;
        exp_q.delete();
        chk("midrst_out", out, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_ready", cfg_ready, 1'b1);
`ifdef HEARTBEAT_IRQ_EN
        chk("midrst_irq", irq, 1'b0);
`endif
        @(posedge clk);
        #1;
        chk("midrst_hold_busy", busy, 1'b0);
        @(negedge clk);
        #2;
        nreset = 1'b1;
        @(negedge clk);
        // period=2 count=2 gap=1: pulses A+3, A+6, done A+7
        issue(8'd2, 4'd2, 8'd1, -1, a);
        wait_cyc(a + 8);
        chk("busy_after_reset_burst", busy, 1'b0);

`ifdef HEARTBEAT_IRQ_EN
        // irq still set from the last completion
        chk("irq_held", irq, 1'b1);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        chk("irq_cleared", irq, 1'b0);
        issue(8'd0, 4'd1, 8'd0, -1, a);
        wait_cyc(a + 1);
        chk("irq_rises_with_done", irq, 1'b1);
        wait_cyc(a + 3);
        chk("irq_holds", irq, 1'b1);
        issue(8'd0, 4'd1, 8'd0, -1, a);
        wait_cyc(a);
        irq_clr = 1'b1;
        @(posedge clk);
        #1;
        irq_clr = 1'b0;
        wait_cyc(a + 1);
        chk("irq_set_beats_clr", irq, 1'b1);
        irq_clr = 1'b1;
        @(posedge clk);
        #1;
        irq_clr = 1'b0;
        wait_cyc(a + 2);
        chk("irq_clr_alone", irq, 1'b0);
`endif

        // All expected events must have been observed
        for (int k = 0; k < 100 && exp_q.size() > 0; k++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d events outstanding, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
